// File: rtl/alu_issue_unit.sv
// Issue/writeback driver for an external combinational RV32I ALU (OP / OP-IMM only).
// Build option: define ISSUE_ILLEGAL_TRAP_EN to pulse `illegal` when an instruction is rejected.
//
// state     | meaning
// IDLE      | ready for a new instruction word
// DECODE    | read operands, build ALU opcode, classify legal/illegal
// EXECUTE   | operands held on the ALU while the latency counter runs down
// WRITEBACK | retire pulse visible; result already committed to the register file
module alu_issue_unit #(
    parameter int XLEN        = 32,
    parameter int NREGS       = 32,
    parameter int ALU_LATENCY = 1
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr_data,
    output logic [XLEN-1:0] alu_operand_a,
    output logic [XLEN-1:0] alu_operand_b,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            busy,
    output logic            illegal
);

    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_WRITEBACK} state_t;

    state_t          state, state_nxt;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] rf [NREGS];
    logic [CW-1:0]   cnt;

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd, rs1, rs2;
    logic            is_r, is_i, is_shift, dec_legal;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_op;

    assign opc = instr_q[6:0];
    assign rd  = instr_q[11:7];
    assign f3  = instr_q[14:12];
    assign rs1 = instr_q[19:15];
    assign rs2 = instr_q[24:20];
    assign f7  = instr_q[31:25];

    always_comb begin
        is_r     = (opc == 7'b0110011);
        is_i     = (opc == 7'b0010011);
        is_shift = is_i && ((f3 == 3'b001) || (f3 == 3'b101));
        dec_a    = (rs1 == 5'd0) ? '0 : rf[rs1];
        dec_b    = '0;
        dec_op   = '0;
        dec_legal = 1'b0;
        if (is_r) begin
            dec_b     = (rs2 == 5'd0) ? '0 : rf[rs2];
            dec_op    = {instr_q[30], f3};
            dec_legal = (f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end else if (is_i) begin
            // Only SRAI may carry bit 30 into the opcode; ADDI must never turn into SUB.
            dec_op = {(f3 == 3'b101) && instr_q[30], f3};
            if (is_shift) begin
                dec_b     = {{(XLEN-5){1'b0}}, instr_q[24:20]};
                dec_legal = !instr_q[31] && (instr_q[29:25] == 5'd0);
            end else begin
                dec_b     = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
                dec_legal = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (instr_valid) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = dec_legal ? S_EXECUTE : S_WRITEBACK;
            S_EXECUTE:   if (cnt == CW'(1)) state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            cnt           <= '0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_opcode    <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            case (state)
                S_IDLE: if (instr_valid) instr_q <= instr_data;
                S_DECODE: if (dec_legal) begin
                    alu_operand_a <= dec_a;
                    alu_operand_b <= dec_b;
                    alu_opcode    <= dec_op;
                    cnt           <= CW'(ALU_LATENCY);
                end
                S_EXECUTE: if (cnt == CW'(1)) begin
                    // Operands are frozen, so the result sampled here is the one retired in WRITEBACK.
                    wb_valid <= 1'b1;
                    wb_rd    <= rd;
                    wb_data  <= alu_result;
                    if (rd != 5'd0) rf[rd] <= alu_result;
                end else begin
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)
            illegal_q <= 1'b0;
        else
            illegal_q <= (state == S_DECODE) && !dec_legal;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: architectural RV32I model predicts retires; a monitor checks them.
module tb_alu_issue_unit;
    localparam int L = 1;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_data = '0;
    logic        instr_ready, wb_valid, busy, illegal;
    logic [31:0] alu_operand_a, alu_operand_b, alu_result, wb_data;
    logic [3:0]  alu_opcode;
    logic [4:0]  wb_rd;

    alu_issue_unit #(.XLEN(32), .NREGS(32), .ALU_LATENCY(L)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
        .alu_opcode(alu_opcode), .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .illegal(illegal)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // External ALU stand-in
    function automatic logic [31:0] tb_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return {31'b0, $signed(a) < $signed(b)};
            4'b0011: return {31'b0, a < b};
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = tb_alu(alu_opcode, alu_operand_a, alu_operand_b);

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data, a, b;
        logic [3:0]  op;
        int          edge_at;
    } exp_t;

    exp_t        wb_q[$];
    int          ill_q[$];
    logic [31:0] mreg [32];
    int          edge_cnt = 0;
    int          checks = 0, passes = 0;
    int          prev_h = 0;
    bit          have_prev = 0, prev_legal = 0;

    always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural meaning of one instruction against the model register file
    function automatic void ref_exec(input logic [31:0] w, output bit legal, output logic [3:0] op,
                                     output logic [31:0] a, output logic [31:0] b, output logic [31:0] res);
        logic [2:0] f3;
        logic [6:0] f7;
        bit alt;
        f3 = w[14:12];
        f7 = w[31:25];
        a = mreg[w[19:15]];
        b = '0; op = '0; legal = 0; alt = 0; res = '0;
        if (w[6:0] == 7'h33) begin
            b     = mreg[w[24:20]];
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            alt   = w[30];
            op    = {alt, f3};
        end else if (w[6:0] == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b     = {27'b0, w[24:20]};
                legal = !w[31] && (w[29:25] == 5'd0);
                alt   = (f3 == 3'd5) && w[30];
            end else begin
                b     = {{20{w[31]}}, w[31:20]};
                legal = 1;
            end
            op = {alt, f3};
        end
        case (f3)
            3'd0: res = alt ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: res = a | b;
            default: res = a & b;
        endcase
    endfunction

    // Offer w; b2b keeps valid asserted straight after the previous handshake
    task automatic issue(input logic [31:0] w, input bit b2b);
        int guard;
        int h;
        bit legal;
        exp_t e;
        if (!b2b) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge CLOCK_50);
        end
        instr_valid = 1'b1;
        instr_data  = w;
        guard = 0;
        while (!instr_ready && guard < 30) begin
            @(negedge CLOCK_50);
            guard++;
        end
        if (!instr_ready) begin
            check("accept_timeout", {31'b0, instr_ready}, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        h = edge_cnt + 1;
        if (b2b && have_prev)
            check("accept_gap", h - prev_h, prev_legal ? 3 + L : 3);
        ref_exec(w, legal, e.op, e.a, e.b, e.data);
        e.rd = w[11:7];
        if (legal) begin
            // retire pulse is visible in the cycle after edge h+1+L
            e.edge_at = h + 1 + L;
            wb_q.push_back(e);
            if (e.rd != 5'd0) mreg[e.rd] = e.data;
        end else begin
            ill_q.push_back(h + 1);
        end
        prev_h = h; prev_legal = legal; have_prev = 1;
        @(negedge CLOCK_50);
    endtask

    task automatic drain();
        int guard = 0;
        instr_valid = 1'b0;
        while ((wb_q.size() != 0 || ill_q.size() != 0 || busy) && guard < 40) begin
            @(negedge CLOCK_50);
            guard++;
        end
        check("drain", wb_q.size() + ill_q.size(), 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    check("unexpected_wb_valid", {31'b0, wb_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = wb_q.pop_front();
                    check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                    check("wb_data", wb_data, e.data);
                    check("alu_opcode", {28'b0, alu_opcode}, {28'b0, e.op});
                    check("alu_operand_a", alu_operand_a, e.a);
                    check("alu_operand_b", alu_operand_b, e.b);
                    check("wb_timing", edge_cnt, e.edge_at);
                end
            end
            begin
                bit exp_ill;
                exp_ill = (ill_q.size() != 0) && (ill_q[0] == edge_cnt);
                if (illegal || exp_ill) begin
`ifdef ISSUE_ILLEGAL_TRAP_EN
                    check("illegal_pulse", {31'b0, illegal}, {31'b0, exp_ill});
`else
                    check("illegal_tied_low", {31'b0, illegal}, 32'd0);
`endif
                end
                if (exp_ill) void'(ill_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        repeat (3) @(negedge CLOCK_50);
        check("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_operand_a", alu_operand_a, 32'd0);
        check("rst_operand_b", alu_operand_b, 32'd0);
        check("rst_opcode", {28'b0, alu_opcode}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        RESET = 1'b0;
        @(negedge CLOCK_50);

        issue(32'h0050_0093, 0);   // ADDI x1,x0,5
        issue(32'h0010_0113, 1);   // ADDI x2,x0,1
        issue(32'h4020_01B3, 1);   // SUB  x3,x0,x2
        issue(32'h0070_0013, 1);   // ADDI x0,x0,7
        issue(32'h0000_0233, 1);   // ADD  x4,x0,x0
        issue(32'h4041_D293, 1);   // SRAI x5,x3,4
        issue(32'h4000_0413, 1);   // ADDI x8,x0,0x400
        issue(32'h0000_007F, 1);   // not OP / OP-IMM
        issue(32'h0030_0493, 1);   // ADDI x9,x0,3
        drain();

        // Reset while ADDI x6,x0,9 sits in EXECUTE
        instr_valid = 1'b1;
        instr_data  = 32'h0090_0313;
        @(negedge CLOCK_50);       // handshake edge passed, DECODE
        instr_valid = 1'b0;
        @(negedge CLOCK_50);       // EXECUTE
        check("exec_busy", {31'b0, busy}, 32'd1);
        RESET = 1'b1;
        #1;
        check("midrst_instr_ready", {31'b0, instr_ready}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        repeat (2) begin
            @(negedge CLOCK_50);
            check("midrst_no_wb", {31'b0, wb_valid}, 32'd0);
            check("midrst_ready_held", {31'b0, instr_ready}, 32'd1);
        end
        RESET = 1'b0;
        for (int i = 0; i < 32; i++) mreg[i] = '0;
        have_prev = 0;
        @(negedge CLOCK_50);
        issue(32'h0003_03B3, 0);   // ADD x7,x6,x0 -> x6 must read back 0

        for (int n = 0; n < 200; n++) begin
            logic [31:0] w;
            logic [4:0]  rd, rs1, rs2;
            logic [2:0]  f3;
            int          k;
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            k   = $urandom_range(0, 9);
            if (k == 0) begin
                case ($urandom_range(0, 3))
                    0: begin w = $urandom; w[6:0] = 7'h03; end
                    1: w = enc_r(7'h01, rs2, rs1, f3, rd);
                    2: w = enc_r(7'h20, rs2, rs1, 3'd1, rd);
                    default: w = enc_i({7'h21, rs2}, rs1, 3'd5, rd);
                endcase
            end else if (k <= 4) begin
                w = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                          rs2, rs1, f3, rd);
            end else if (f3 == 3'd1) begin
                w = enc_i({7'h00, rs2}, rs1, f3, rd);
            end else if (f3 == 3'd5) begin
                w = enc_i({1'b0, 1'($urandom_range(0, 1)), 5'd0, rs2}, rs1, f3, rd);
            end else begin
                w = enc_i(12'($urandom), rs1, f3, rd);
            end
            issue(w, $urandom_range(0, 3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
